// File: rtl/dup_lock_fsm_if.sv
// Bundles the condition/key inputs and the registered output word of the keyed ring controller.
// Latency: none, this is plain wiring.
// Backpressure: none; the controller evaluates every cycle and its outputs carry no ready.
interface dup_lock_fsm_if #(
    parameter int NUM_STATES = 8,
    parameter int X_W        = 4,
    parameter int Y_W        = 8,
    parameter int KEY_W      = 3
);
    localparam int SW = $clog2(NUM_STATES);

    logic [X_W-1:0]   x;
    logic [KEY_W-1:0] keyinput;
    logic [Y_W-1:0]   y;
    logic             y_vld;
    logic [SW-1:0]    state_o;

    // Stimulus side drives conditions and key, observes the registered outputs.
    modport master (
        output x,
        output keyinput,
        input  y,
        input  y_vld,
        input  state_o
    );

    // Controller side.
    modport slave (
        input  x,
        input  keyinput,
        output y,
        output y_vld,
        output state_o
    );
endinterface

// File: rtl/dup_lock_fsm.sv
// Keyed ring controller: NUM_STATES real states, the first KEY_W successors of R0 have decoy twins that corrupt y.
// Latency: one cycle from x/keyinput sample to y/y_vld/state_o update.
// Backpressure: none; accepts x every cycle. Optional macro DUP_LOCK_TRAP_EN adds an absorbing trap state.
module dup_lock_fsm #(
    parameter int               NUM_STATES  = 8,
    parameter int               X_W         = 4,
    parameter int               Y_W         = 8,
    parameter int               KEY_W       = 3,
    parameter logic [KEY_W-1:0] CORRECT_KEY = 3'b101,
    parameter logic [Y_W-1:0]   DECOY_MASK  = 8'hA5,
    parameter int               TRAP_LIMIT  = 4
) (
    input  logic          clk,
    input  logic          rst,
    dup_lock_fsm_if.slave bus
);

    localparam int SW = $clog2(NUM_STATES);
    localparam int CW = $clog2(TRAP_LIMIT + 1);

    // The state is a mode plus a ring index; a duplicate keeps its twin's index.
    typedef enum logic [1:0] {
        MODE_REAL = 2'd0,
        MODE_DUP  = 2'd1,
        MODE_TRAP = 2'd2
    } mode_e;

    mode_e          mode_q, mode_d;
    logic [SW-1:0]  idx_q, idx_d;
    logic [Y_W-1:0] y_q, y_d;
    logic           y_vld_q, y_vld_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    int             s_i;
    int             t_i;
    int             kbit_i;
    logic           cond_a;
    logic           cond_b;
    logic           key_bad;
    logic           legal;
    logic           trap_hit;
    logic [Y_W-1:0] onehot;

    // State, output and decoy-counter registers; reset wins over any transition.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q  <= MODE_REAL;
            idx_q   <= '0;
            y_q     <= '0;
            y_vld_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            mode_q  <= mode_d;
            idx_q   <= idx_d;
            y_q     <= y_d;
            y_vld_q <= y_vld_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state, next output word and counter update.
    always_comb begin
        // Defaults describe R0 with a quiet output: the abort and recovery result.
        mode_d  = MODE_REAL;
        idx_d   = '0;
        y_d     = '0;
        y_vld_d = 1'b0;
        cnt_d   = cnt_q;

        s_i    = int'(idx_q);
        t_i    = (s_i >= NUM_STATES - 1) ? 0 : s_i + 1;
        kbit_i = (t_i >= 1) ? t_i - 1 : 0;

        cond_a  = |(bus.x & (X_W'(1) << (s_i % X_W)));
        cond_b  = |(bus.x & (X_W'(1) << ((s_i + 1) % X_W)));
        // Only the key bit of the target matters, so a wrong key never sticks.
        key_bad = (t_i >= 1) && (t_i <= KEY_W) &&
                  (|((bus.keyinput ^ CORRECT_KEY) & (KEY_W'(1) << kbit_i)));
        onehot  = Y_W'(1) << (t_i % Y_W);

`ifdef DUP_LOCK_TRAP_EN
        trap_hit = (cnt_q == CW'(TRAP_LIMIT - 1));
`else
        trap_hit = 1'b0;
`endif

        case (mode_q)
            MODE_REAL: legal = (s_i < NUM_STATES);
            MODE_DUP:  legal = (s_i >= 1) && (s_i <= KEY_W);
            default:   legal = 1'b0;
        endcase

`ifdef DUP_LOCK_TRAP_EN
        if (mode_q == MODE_TRAP) begin
            mode_d = MODE_TRAP;
        end else
`endif
        if (legal) begin
            if (cond_a) begin
                if (key_bad) begin
                    if (cnt_q != CW'(TRAP_LIMIT)) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                    if (trap_hit) begin
                        mode_d = MODE_TRAP;
                    end else begin
                        mode_d  = MODE_DUP;
                        idx_d   = SW'(t_i);
                        y_d     = onehot ^ DECOY_MASK;
                        y_vld_d = 1'b1;
                    end
                end else begin
                    mode_d  = MODE_REAL;
                    idx_d   = SW'(t_i);
                    y_d     = onehot;
                    y_vld_d = 1'b1;
                end
            end else if (!cond_b) begin
                // Hold: stay put, output goes quiet.
                mode_d = mode_q;
                idx_d  = idx_q;
            end
        end
    end

    assign bus.y       = y_q;
    assign bus.y_vld   = y_vld_q;
    // A duplicate reports its twin's index; the trap reports 0.
    assign bus.state_o = (mode_q == MODE_TRAP) ? '0 : idx_q;

endmodule

// File: tb/tb_dup_lock_fsm.sv
// Directed bench for dup_lock_fsm with hand-computed expected state, output word and valid.
// Latency: each step drives inputs, waits one rising edge, samples 1 ns later.
// Backpressure: not applicable; trap expectations follow DUP_LOCK_TRAP_EN.
module tb_dup_lock_fsm;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    dup_lock_fsm_if #(.NUM_STATES(8), .X_W(4), .Y_W(8), .KEY_W(3)) bus ();

    dup_lock_fsm #(
        .NUM_STATES (8),
        .X_W        (4),
        .Y_W        (8),
        .KEY_W      (3),
        .CORRECT_KEY(3'b101),
        .DECOY_MASK (8'hA5),
        .TRAP_LIMIT (4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_chk  = 0;
    int n_pass = 0;

    logic [7:0] ring_y [8] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic r, input logic [3:0] xv, input logic [2:0] kv,
                        input logic [2:0] es, input logic [7:0] ey, input logic ev,
                        input string tag);
        rst          = r;
        bus.x        = xv;
        bus.keyinput = kv;
        @(posedge clk);
        #1;
        check({tag, ".state"}, 32'(bus.state_o), 32'(es));
        check({tag, ".y"},     32'(bus.y),       32'(ey));
        check({tag, ".vld"},   32'(bus.y_vld),   32'(ev));
    endtask

    task automatic correct_run(input string pfx);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 4'b1111, 3'b101, 3'((i + 1) % 8), ring_y[i], 1'b1,
                 $sformatf("%s_%0d", pfx, i));
        end
    endtask

    initial begin
        rst          = 1'b1;
        bus.x        = '0;
        bus.keyinput = '0;

        // Reset state
        step(1'b1, 4'b0000, 3'b000, 3'd0, 8'h00, 1'b0, "reset");

        // Correct key walks the whole ring with clean one-hot outputs
        correct_run("ring");

        // Wrong bit 0 enters decoy D1, then a correct key leaves to real R2
        step(1'b0, 4'b0001, 3'b100, 3'd1, 8'hA7, 1'b1, "d1_enter");
        step(1'b0, 4'b0010, 3'b101, 3'd2, 8'h04, 1'b1, "d1_to_r2");

        // Abort from R2, climb back, then hold three cycles
        step(1'b0, 4'b1000, 3'b101, 3'd0, 8'h00, 1'b0, "abort_r2");
        step(1'b0, 4'b1111, 3'b101, 3'd1, 8'h02, 1'b1, "climb_r1");
        step(1'b0, 4'b1111, 3'b101, 3'd2, 8'h04, 1'b1, "climb_r2");
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 4'b0000, 3'b101, 3'd2, 8'h00, 1'b0, $sformatf("hold_%0d", i));
        end

        // Reset arriving on the same edge as an advance out of D1
        step(1'b0, 4'b1000, 3'b101, 3'd0, 8'h00, 1'b0, "abort_again");
        step(1'b0, 4'b0001, 3'b100, 3'd1, 8'hA7, 1'b1, "d1_again");
        step(1'b1, 4'b0010, 3'b101, 3'd0, 8'h00, 1'b0, "rst_mid");
        correct_run("ring2");

        // Wrong bits 1 and 2 give D2, D3; past KEY_W the key is ignored
        step(1'b0, 4'b0001, 3'b101, 3'd1, 8'h02, 1'b1, "to_r1");
        step(1'b0, 4'b0010, 3'b111, 3'd2, 8'hA1, 1'b1, "d2_enter");
        step(1'b0, 4'b0100, 3'b001, 3'd3, 8'hAD, 1'b1, "d3_enter");
        step(1'b0, 4'b1000, 3'b000, 3'd4, 8'h10, 1'b1, "d3_to_r4");

        // Repeated decoy entries into D1 with a fully wrong key
        step(1'b1, 4'b0000, 3'b000, 3'd0, 8'h00, 1'b0, "trap_rst");
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 4'b0001, 3'b000, 3'd1, 8'hA7, 1'b1, $sformatf("decoy_%0d", k));
            step(1'b0, 4'b0100, 3'b000, 3'd0, 8'h00, 1'b0, $sformatf("dabort_%0d", k));
        end
`ifdef DUP_LOCK_TRAP_EN
        step(1'b0, 4'b0001, 3'b000, 3'd0, 8'h00, 1'b0, "trap_enter");
        for (int k = 0; k < 10; k++) begin
            step(1'b0, 4'(k * 5 + 1), 3'(k), 3'd0, 8'h00, 1'b0, $sformatf("trap_hold_%0d", k));
        end
`else
        step(1'b0, 4'b0001, 3'b000, 3'd1, 8'hA7, 1'b1, "decoy_3");
        step(1'b0, 4'b0100, 3'b000, 3'd0, 8'h00, 1'b0, "dabort_3");
        step(1'b0, 4'b0001, 3'b000, 3'd1, 8'hA7, 1'b1, "decoy_4");
`endif
        step(1'b1, 4'b0001, 3'b000, 3'd0, 8'h00, 1'b0, "recover_rst");
        step(1'b0, 4'b1111, 3'b101, 3'd1, 8'h02, 1'b1, "recover_adv");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
